// File: rtl/systolic_matmul_engine.sv
// Output-stationary N_SIZE x N_SIZE systolic matrix-multiply engine (C = A x B).
// Operand beats (column k of A, row k of B) enter through a valid/ready
// handshake. They are skewed internally and accumulated in place. The array is
// then flushed and C is drained one row per beat under backpressure. Finally
// the engine self-clears for the next job.
// Optional build macro: SYSTOLIC_SIGNED_EN selects two's-complement operands
// and a sign-extended, signed accumulation. Without it, all arithmetic is
// unsigned.
module systolic_matmul_engine #(
  parameter int DATAWIDTH = 8,
  parameter int N_SIZE    = 3,
  parameter int K_MAX     = 16,
  parameter int ACC_WIDTH = 2*DATAWIDTH + $clog2(K_MAX)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [N_SIZE*DATAWIDTH-1:0]   matrix_a_in,
  input  logic [N_SIZE*DATAWIDTH-1:0]   matrix_b_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [$clog2(N_SIZE)-1:0]     out_row,
  output logic [N_SIZE*ACC_WIDTH-1:0]   matrix_c_out,
  output logic                          k_overflow
);

  localparam int DW = DATAWIDTH;
  localparam int N  = N_SIZE;
  localparam int PW = 2*DATAWIDTH;
  localparam int RW = $clog2(N_SIZE);
  localparam int CW = $clog2(K_MAX + 1);
  localparam int FW = $clog2(2*N_SIZE);

  typedef enum logic [1:0] {LOAD, FLUSH, DRAIN} state_t;

  state_t          state;
  logic [CW-1:0]   beat_cnt;
  logic [FW-1:0]   flush_cnt;

  logic            accept;
  logic            job_done;

  logic [DW-1:0]   a_gated [N];
  logic [DW-1:0]   b_gated [N];
  logic [DW-1:0]   a_skew  [N];
  logic [DW-1:0]   b_skew  [N];

  logic [DW-1:0]   a_in    [N][N];
  logic [DW-1:0]   b_in    [N][N];
  logic [DW-1:0]   a_reg   [N][N];
  logic [DW-1:0]   b_reg   [N][N];
  logic [ACC_WIDTH-1:0] prod_ext [N][N];
  logic [ACC_WIDTH-1:0] acc      [N][N];

  logic [RW-1:0]            row_idx;
  logic [N*ACC_WIDTH-1:0]   row_vec;

  assign accept   = in_valid && in_ready;
  assign job_done = out_valid && out_ready && out_last;

  // Unpack the operand beat; non-accepted cycles inject zeros so bubbles add nothing.
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_gated[i] = accept ? matrix_a_in[i*DW +: DW] : '0;
      b_gated[i] = accept ? matrix_b_in[i*DW +: DW] : '0;
    end
  end

  // Input skew: row i of A and column i of B are delayed by i cycles.
  assign a_skew[0] = a_gated[0];
  assign b_skew[0] = b_gated[0];

  for (genvar i = 1; i < N; i++) begin : g_skew
    logic [i*DW-1:0] a_chain;
    logic [i*DW-1:0] b_chain;

    // Shift chain of depth i; the oldest element sits in the top slot.
    // NOTE: sequential state uses non-blocking (<=) so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_chain <= '0;
        b_chain <= '0;
      end else if (job_done) begin
        a_chain <= '0;
        b_chain <= '0;
      end else begin
        a_chain <= (a_chain << DW) | (i*DW)'(a_gated[i]);
        b_chain <= (b_chain << DW) | (i*DW)'(b_gated[i]);
      end
    end

    assign a_skew[i] = a_chain[i*DW-1 -: DW];
    assign b_skew[i] = b_chain[i*DW-1 -: DW];
  end

  // PE operand routing: a enters on the left edge and b on the top edge.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = a_skew[i];
      b_in[0][i] = b_skew[i];
      for (int j = 1; j < N; j++) begin
        a_in[i][j] = a_reg[i][j-1];
        b_in[j][i] = b_reg[j-1][i];
      end
    end
  end

  // Per-PE product, extended to the accumulator width.
`ifdef SYSTOLIC_SIGNED_EN
  logic signed [PW-1:0] prod [N][N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod[i][j]     = $signed({{DW{a_in[i][j][DW-1]}}, a_in[i][j]})
                       * $signed({{DW{b_in[i][j][DW-1]}}, b_in[i][j]});
        prod_ext[i][j] = ACC_WIDTH'(prod[i][j]);
      end
    end
  end
`else
  logic [PW-1:0] prod [N][N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod[i][j]     = {{DW{1'b0}}, a_in[i][j]} * {{DW{1'b0}}, b_in[i][j]};
        prod_ext[i][j] = ACC_WIDTH'(prod[i][j]);
      end
    end
  end
`endif

  // PE array: pass a right and b down, and accumulate in place (wraps modulo 2^ACC_WIDTH).
  // NOTE: these are individual flops, not a RAM, so resetting them costs nothing special.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
          acc[i][j]   <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (job_done) begin
            a_reg[i][j] <= '0;
            b_reg[i][j] <= '0;
            acc[i][j]   <= '0;
          end else begin
            a_reg[i][j] <= a_in[i][j];
            b_reg[i][j] <= b_in[i][j];
            acc[i][j]   <= acc[i][j] + prod_ext[i][j];
          end
        end
      end
    end
  end

  // Select the row to present next: row 0 on DRAIN entry, otherwise out_row+1.
  always_comb begin
    row_idx = '0;
    if (state == DRAIN && out_row != RW'(N-1)) row_idx = out_row + RW'(1);
    for (int j = 0; j < N; j++) row_vec[j*ACC_WIDTH +: ACC_WIDTH] = acc[row_idx][j];
  end

  // Control FSM: LOAD beats, FLUSH the pipeline, DRAIN rows, then auto-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_row      <= '0;
      matrix_c_out <= '0;
      k_overflow   <= 1'b0;
      beat_cnt     <= '0;
      flush_cnt    <= '0;
    end else begin
      k_overflow <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (in_last || beat_cnt == CW'(K_MAX-1)) begin
              state      <= FLUSH;
              in_ready   <= 1'b0;
              flush_cnt  <= '0;
              k_overflow <= !in_last;
            end
          end
        end
        FLUSH: begin
          // The final product reaches PE(N-1,N-1) 2N-2 edges after the last beat.
          if (flush_cnt == FW'(2*N-2)) begin
            state        <= DRAIN;
            out_valid    <= 1'b1;
            out_row      <= '0;
            out_last     <= 1'b0;
            matrix_c_out <= row_vec;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              state        <= LOAD;
              in_ready     <= 1'b1;
              out_valid    <= 1'b0;
              out_last     <= 1'b0;
              out_row      <= '0;
              matrix_c_out <= '0;
              beat_cnt     <= '0;
            end else begin
              out_row      <= out_row + RW'(1);
              out_last     <= (out_row + RW'(1)) == RW'(N-1);
              matrix_c_out <= row_vec;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
